// File: rtl/chess_display_pkg.sv
// Shared constants for the chess display: screen geometry, region numbering,
// redraw scheduler state encoding and the square-offset lookup.
package chess_display_pkg;

   localparam int LCD_WIDTH     = 240;
   localparam int LCD_HEIGHT    = 320;
   localparam int BANNER_HEIGHT = 40;
   localparam int SQUARE_SIZE   = 30;

   localparam int REGION_TOP    = 0;
   localparam int REGION_SQ0    = 1;
   localparam int REGION_BOTTOM = 65;
   localparam int NUM_REGIONS   = 66;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DRAW = 2'd2
   } state_t;

   // Pixel offset of board column/row idx; a table keeps multipliers out of the datapath.
   function automatic logic [7:0] square_offset(input logic [2:0] idx);
      logic [7:0] off;
      case (idx)
         3'd0:    off = 8'd0;
         3'd1:    off = 8'd30;
         3'd2:    off = 8'd60;
         3'd3:    off = 8'd90;
         3'd4:    off = 8'd120;
         3'd5:    off = 8'd150;
         3'd6:    off = 8'd180;
         default: off = 8'd210;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/region_origin_lut.sv
// Combinational map from region index to its origin and size on the LT24 screen.
module region_origin_lut
   import chess_display_pkg::*;
(
   input  logic [6:0] region_id_i,
   output logic [7:0] x0_o,
   output logic [8:0] y0_o,
   output logic [7:0] w_o,
   output logic [8:0] h_o
);

   logic [5:0] sq;

   always_comb begin
      sq   = 6'(region_id_i - 7'(REGION_SQ0));
      x0_o = '0;
      y0_o = '0;
      w_o  = 8'(LCD_WIDTH);
      h_o  = 9'(BANNER_HEIGHT);
      if (region_id_i == 7'(REGION_BOTTOM)) begin
         y0_o = 9'(LCD_HEIGHT - BANNER_HEIGHT);
      end else if (region_id_i != 7'(REGION_TOP)) begin
         // sq[2:0] is the board column, sq[5:3] the board row.
         x0_o = square_offset(sq[2:0]);
         y0_o = 9'(BANNER_HEIGHT) + {1'b0, square_offset(sq[5:3])};
         w_o  = 8'(SQUARE_SIZE);
         h_o  = 9'(SQUARE_SIZE);
      end
   end

endmodule

// File: rtl/board_redraw_scheduler.sv
// Redraws only dirty screen regions, streaming their pixel addresses to the LT24
// interface with a pixelWrite/pixelReady handshake.
module board_redraw_scheduler
   import chess_display_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        fullRedraw,
   input  logic [63:0] squareDirty,
   input  logic [1:0]  bannerDirty,
   input  logic        pixelReady,
   output logic [7:0]  xAddr,
   output logic [8:0]  yAddr,
   output logic        pixelWrite,
   output logic        busy,
   output logic        regionDone,
   output logic [6:0]  regionId
);

   // Handshake: a pixel is transferred on every rising clock edge where
   // pixelWrite and pixelReady are both high; while pixelReady is low the
   // address and pixelWrite are held stable.

   state_t      state_q, state_d;
   logic [65:0] dirty_q, dirty_d;
   logic [6:0]  region_q, region_d;
   logic [7:0]  x_q, x_d;
   logic [8:0]  y_q, y_d;
   logic        wr_q, wr_d;
   logic        done_q, done_d;
   logic [7:0]  x0_q, x0_d;
   logic [7:0]  xl_q, xl_d;
   logic [8:0]  yl_q, yl_d;

   logic [65:0] set_vec;
   logic [65:0] clr_vec;
   logic [6:0]  sel_idx;
   logic [7:0]  lut_x0;
   logic [8:0]  lut_y0;
   logic [7:0]  lut_w;
   logic [8:0]  lut_h;

   region_origin_lut u_lut (
      .region_id_i (region_q),
      .x0_o        (lut_x0),
      .y0_o        (lut_y0),
      .w_o         (lut_w),
      .h_o         (lut_h)
   );

   assign set_vec = {bannerDirty[1], squareDirty, bannerDirty[0]} | {66{fullRedraw}};

   // Lowest dirty index wins.
   always_comb begin
      sel_idx = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (dirty_q[i]) sel_idx = 7'(i);
      end
   end

   always_comb begin
      state_d  = state_q;
      region_d = region_q;
      x_d      = x_q;
      y_d      = y_q;
      wr_d     = wr_q;
      done_d   = 1'b0;
      x0_d     = x0_q;
      xl_d     = xl_q;
      yl_d     = yl_q;
      clr_vec  = '0;
      case (state_q)
         ST_IDLE: begin
            if (|dirty_q) begin
               region_d         = sel_idx;
               clr_vec[sel_idx] = 1'b1;
               state_d          = ST_LOAD;
            end
         end
         ST_LOAD: begin
            x0_d    = lut_x0;
            xl_d    = lut_x0 + lut_w - 8'd1;
            yl_d    = lut_y0 + lut_h - 9'd1;
            x_d     = lut_x0;
            y_d     = lut_y0;
            wr_d    = 1'b1;
            state_d = ST_DRAW;
         end
         ST_DRAW: begin
            if (wr_q && pixelReady) begin
               if (x_q == xl_q) begin
                  if (y_q == yl_q) begin
                     wr_d    = 1'b0;
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     x_d = x0_q;
                     y_d = y_q + 9'd1;
                  end
               end else begin
                  x_d = x_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A set arriving on the selection edge keeps the bit, so the region is redrawn again.
      dirty_d = (dirty_q & ~clr_vec) | set_vec;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         dirty_q  <= '1;
         region_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         wr_q     <= 1'b0;
         done_q   <= 1'b0;
         x0_q     <= '0;
         xl_q     <= '0;
         yl_q     <= '0;
      end else begin
         state_q  <= state_d;
         dirty_q  <= dirty_d;
         region_q <= region_d;
         x_q      <= x_d;
         y_q      <= y_d;
         wr_q     <= wr_d;
         done_q   <= done_d;
         x0_q     <= x0_d;
         xl_q     <= xl_d;
         yl_q     <= yl_d;
      end
   end

   assign xAddr      = x_q;
   assign yAddr      = y_q;
   assign pixelWrite = wr_q;
   assign busy       = (state_q != ST_IDLE);
   assign regionDone = done_q;
   assign regionId   = region_q;

endmodule

// File: tb/tb_board_redraw_scheduler.sv
// Directed bench for board_redraw_scheduler with a pixel/region scoreboard.
module tb_board_redraw_scheduler;

   logic        clock;
   logic        reset_n;
   logic        fullRedraw;
   logic [63:0] squareDirty;
   logic [1:0]  bannerDirty;
   logic        pixelReady;
   logic [7:0]  xAddr;
   logic [8:0]  yAddr;
   logic        pixelWrite;
   logic        busy;
   logic        regionDone;
   logic [6:0]  regionId;

   int checks   = 0;
   int failures = 0;
   int writes_seen = 0;
   int dones_seen  = 0;

   logic [16:0] exp_q[$];
   logic [6:0]  reg_q[$];

   board_redraw_scheduler dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .fullRedraw  (fullRedraw),
      .squareDirty (squareDirty),
      .bannerDirty (bannerDirty),
      .pixelReady  (pixelReady),
      .xAddr       (xAddr),
      .yAddr       (yAddr),
      .pixelWrite  (pixelWrite),
      .busy        (busy),
      .regionDone  (regionDone),
      .regionId    (regionId)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected pixel sequence of a region, row-major.
   task automatic push_region(input int r);
      int x0, y0, w, h, s;
      if (r == 0) begin
         x0 = 0; y0 = 0; w = 240; h = 40;
      end else if (r == 65) begin
         x0 = 0; y0 = 280; w = 240; h = 40;
      end else begin
         s  = r - 1;
         x0 = 30 * (s % 8);
         y0 = 40 + 30 * (s / 8);
         w  = 30; h = 30;
      end
      for (int y = y0; y < y0 + h; y++)
         for (int x = x0; x < x0 + w; x++)
            exp_q.push_back({8'(x), 9'(y)});
      reg_q.push_back(7'(r));
   endtask

   // Monitor: a write seen here is accepted on the following rising edge.
   always @(negedge clock) begin
      logic [16:0] e;
      logic [6:0]  rr;
      if (reset_n && pixelWrite && pixelReady) begin
         writes_seen++;
         check("write_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pixel_addr", 32'({xAddr, yAddr}), 32'(e));
         end
      end
      if (reset_n && regionDone) begin
         dones_seen++;
         check("done_expected", 32'(reg_q.size() != 0), 32'd1);
         if (reg_q.size() != 0) begin
            rr = reg_q.pop_front();
            check("done_region_id", 32'(regionId), 32'(rr));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (exp_q.size() == 0 && reg_q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic wait_writes(input string tag, input int base, input int n, input int budget);
      for (int i = 0; i < budget && (writes_seen - base) < n; i++) tick();
      check(tag, 32'((writes_seen - base) >= n), 32'd1);
   endtask

   initial begin
      int wb, db;
      reset_n     = 1'b0;
      fullRedraw  = 1'b0;
      squareDirty = '0;
      bannerDirty = '0;
      pixelReady  = 1'b1;
      tick();
      tick();
      check("rst_xaddr", 32'(xAddr), 32'd0);
      check("rst_yaddr", 32'(yAddr), 32'd0);
      check("rst_write", 32'(pixelWrite), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(regionDone), 32'd0);
      check("rst_region", 32'(regionId), 32'd0);

      // Full redraw after reset.
      for (int r = 0; r < 66; r++) push_region(r);
      wb = writes_seen; db = dones_seen;
      reset_n = 1'b1;
      tick();
      check("full_load_busy", 32'(busy), 32'd1);
      check("full_load_write", 32'(pixelWrite), 32'd0);
      check("full_load_region", 32'(regionId), 32'd0);
      tick();
      check("full_first_write", 32'(pixelWrite), 32'd1);
      wait_drain("full_drain", 80000);
      check("full_writes", 32'(writes_seen - wb), 32'd76800);
      check("full_dones", 32'(dones_seen - db), 32'd66);
      check("full_idle_busy", 32'(busy), 32'd0);
      check("full_idle_write", 32'(pixelWrite), 32'd0);

      // Single square 9 with latency checks.
      tick();
      push_region(10);
      wb = writes_seen; db = dones_seen;
      squareDirty[9] = 1'b1;
      tick();
      squareDirty = '0;
      check("sq9_e0_write", 32'(pixelWrite), 32'd0);
      check("sq9_e0_busy", 32'(busy), 32'd0);
      tick();
      check("sq9_e1_region", 32'(regionId), 32'd10);
      check("sq9_e1_busy", 32'(busy), 32'd1);
      check("sq9_e1_write", 32'(pixelWrite), 32'd0);
      tick();
      check("sq9_e2_write", 32'(pixelWrite), 32'd1);
      check("sq9_e2_x", 32'(xAddr), 32'd30);
      check("sq9_e2_y", 32'(yAddr), 32'd70);
      wait_drain("sq9_drain", 2000);
      check("sq9_writes", 32'(writes_seen - wb), 32'd900);
      check("sq9_dones", 32'(dones_seen - db), 32'd1);

      // Squares 63 and 0 together, with a 5-cycle stall inside square 0.
      push_region(1);
      push_region(64);
      wb = writes_seen; db = dones_seen;
      squareDirty[63] = 1'b1;
      squareDirty[0]  = 1'b1;
      tick();
      squareDirty = '0;
      wait_writes("stall_reach", wb, 100, 500);
      pixelReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_write", 32'(pixelWrite), 32'd1);
         if (exp_q.size() != 0)
            check("stall_addr", 32'({xAddr, yAddr}), 32'(exp_q[0]));
      end
      pixelReady = 1'b1;
      wait_drain("pair_drain", 4000);
      check("pair_writes", 32'(writes_seen - wb), 32'd1800);
      check("pair_dones", 32'(dones_seen - db), 32'd2);

      // Square 9 re-pulsed on its own selection edge.
      push_region(10);
      push_region(10);
      wb = writes_seen; db = dones_seen;
      squareDirty[9] = 1'b1;
      tick();
      tick();
      squareDirty = '0;
      wait_drain("redo_drain", 4000);
      check("redo_writes", 32'(writes_seen - wb), 32'd1800);
      check("redo_dones", 32'(dones_seen - db), 32'd2);

      // Reset in the middle of a bottom-banner draw.
      push_region(65);
      wb = writes_seen; db = dones_seen;
      bannerDirty[1] = 1'b1;
      tick();
      bannerDirty = '0;
      wait_writes("bot_reach", wb, 100, 500);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("mid_rst_write", 32'(pixelWrite), 32'd0);
      check("mid_rst_done", 32'(regionDone), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_region", 32'(regionId), 32'd0);
      exp_q.delete();
      reg_q.delete();
      push_region(0);
      wb = writes_seen; db = dones_seen;
      tick();
      check("restart_done", 32'(regionDone), 32'd0);
      check("restart_region", 32'(regionId), 32'd0);
      wait_writes("restart_reach", wb, 300, 600);
      check("restart_no_done", 32'(dones_seen - db), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/board_redraw_scheduler.md
Name: board_redraw_scheduler

Overview:
- Sequences pixel writes to the LT24 pixel interface. Only screen regions marked dirty are redrawn, replacing the free-running full-frame x/y counters.
- The screen is split into 66 regions: top banner, 64 board squares, bottom banner.
- The block issues xAddr/yAddr/pixelWrite with the pixelReady handshake. A combinational renderer outside the block produces pixelData from xAddr/yAddr.

Parameters:
- LCD_WIDTH, 240, display width in pixels
- LCD_HEIGHT, 320, display height in pixels
- BANNER_HEIGHT, 40, height of the top and bottom banners
- SQUARE_SIZE, 30, board square edge in pixels

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- fullRedraw  in  1  single-cycle pulse; marks all 66 regions dirty
- squareDirty  in  64  per-square dirty pulses; bit s = square s (row = s/8, col = s%8)
- bannerDirty  in  2  bit0 = top banner, bit1 = bottom banner
- pixelReady  in  1  LT24 pixel interface ready
- xAddr  out  8  pixel column
- yAddr  out  9  pixel row
- pixelWrite  out  1  pixel write request
- busy  out  1  high in LOAD or DRAW
- regionDone  out  1  single-cycle pulse after the last pixel of a region is accepted
- regionId  out  7  index of the current or last region (0 = top banner, 1..64 = square 0..63, 65 = bottom banner)

Behaviour:
- Reset (reset_n low at a clock edge):
  - state = IDLE; xAddr = 0, yAddr = 0, pixelWrite = 0, busy = 0, regionDone = 0, regionId = 0.
  - The dirty vector is set to all ones, so a full screen redraw follows every reset.
  - Reset mid-region abandons that region immediately; no regionDone is issued.
- Dirty vector (66 bits):
  - Each bit is set by its input pulse, and all bits are set by fullRedraw.
  - A bit is cleared on the edge its region is selected.
  - If set and clear hit the same bit on the same edge, set wins, so the region is redrawn again later.
- Selection: fixed priority, lowest region index first. Selection is re-evaluated only between regions; a region in progress is never preempted.
- States:
  - IDLE: if any dirty bit is set, capture its index into regionId, clear that bit, go to LOAD. Otherwise stay.
  - LOAD (1 cycle): latch origin x0/y0 and size w/h, set xAddr = x0 and yAddr = y0, assert pixelWrite, go to DRAW.
  - DRAW: while pixelWrite && pixelReady, advance the address.
    - If xAddr == x0+w-1: xAddr = x0, yAddr += 1. Otherwise xAddr += 1.
    - On acceptance of pixel (x0+w-1, y0+h-1): deassert pixelWrite, pulse regionDone, go to IDLE.
    - If pixelReady is low, xAddr, yAddr and pixelWrite hold unchanged.
- Region geometry:
  - Top banner: (0, 0), 240x40.
  - Square s: (30*(s%8), 40 + 30*(s/8)), 30x30.
  - Bottom banner: (0, 280), 240x40.
  - The board rows therefore cover y 40..279.
- Latency: dirty pulse sampled at edge E0, IDLE→LOAD at E1, pixelWrite high after E2. There are 2 idle cycles between consecutive regions (IDLE, LOAD).
- Pixel counts: each square is 900 pixels, each banner 9600; a full redraw is 76800 accepted writes.
- Arithmetic: all address arithmetic is unsigned. Region geometry comes from a constant lookup table; no runtime divider.

Decomposition:
- Package chess_display_pkg holds:
  - LCD_WIDTH, LCD_HEIGHT, BANNER_HEIGHT, SQUARE_SIZE
  - region index constants REGION_TOP = 0, REGION_SQ0 = 1, REGION_BOTTOM = 65, NUM_REGIONS = 66
  - state encoding constants
- One sub-module, region_origin_lut: purely combinational, maps regionId to x0, y0, w, h.

Test Plan:
- Release reset with pixelReady held high → exactly 76800 writes in order top banner, squares 0..63, bottom banner. First address (0,0), last (239,319); 66 regionDone pulses; busy low afterwards.
- squareDirty[9] pulse while idle → 900 writes covering x 30..59, y 70..99, row-major; pixelWrite high 2 edges after the sampling edge; regionId = 10.
- squareDirty[63] and squareDirty[0] pulsed together → square 0 (x 0..29, y 40..69) drawn completely before square 63 (x 210..239, y 250..279).
- pixelReady held low for 5 cycles mid-square → xAddr, yAddr and pixelWrite constant for those cycles; no pixel skipped or repeated; still 900 total.
- squareDirty[9] re-pulsed on the edge square 9 is selected → square 9 redrawn twice; 1800 writes, 2 regionDone pulses.
- reset_n low for one cycle during a bottom-banner draw → pixelWrite = 0 the next cycle, no regionDone; the full 76800-pixel redraw restarts from (0,0).
